// File: rtl/act_unit_par.sv
// Multi-mode activation stage (ReLU / leaky / clipped), LANES elements per beat.
// Define ACT_LEAKY_EN to build the leaky-ReLU datapath; otherwise mode 1 behaves as ReLU.

module act_lane #(
    parameter int DATA_W     = 16,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP_VAL   = 24576
) (
    input  logic [1:0]               mode,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);
    localparam logic signed [DATA_W-1:0] CLIP = DATA_W'(CLIP_VAL);

    logic neg;
    assign neg = x[DATA_W-1];

    always_comb begin
        y = neg ? '0 : x;
        case (mode)
`ifdef ACT_LEAKY_EN
            2'd1: y = neg ? (x >>> LEAK_SHIFT) : x;
`endif
            2'd2: begin
                if (neg)           y = '0;
                else if (x > CLIP) y = CLIP;
                else               y = x;
            end
            default: y = neg ? '0 : x;
        endcase
    end
endmodule

module act_unit_par #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 12,
    parameter int N_CH       = 64,
    parameter int LANES      = 8,
    parameter int LEAK_SHIFT = 3,
    parameter int CLIP_VAL   = 24576
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           valid_in,
    output logic                           ready_out,
    input  logic [1:0]                     mode,
    input  logic [N_CH-1:0][DATA_W-1:0]    input_data,
    output logic [N_CH-1:0][DATA_W-1:0]    output_data,
    output logic                           valid_out,
    input  logic                           ready_in
);
    localparam int BEATS  = N_CH / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]                               state;
    logic [BEAT_W-1:0]                        beat;
    logic [1:0]                               mode_q;
    // Buffer and result are viewed beat-major so one beat is a single index.
    logic [BEATS-1:0][LANES-1:0][DATA_W-1:0]  buf_q;
    logic [BEATS-1:0][LANES-1:0][DATA_W-1:0]  out_q;
    logic [LANES-1:0][DATA_W-1:0]             lane_res;

    assign ready_out   = (state == IDLE);
    assign output_data = out_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        act_lane #(
            .DATA_W    (DATA_W),
            .LEAK_SHIFT(LEAK_SHIFT),
            .CLIP_VAL  (CLIP_VAL)
        ) u_lane (
            .mode(mode_q),
            .x   (buf_q[beat][l]),
            .y   (lane_res[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            beat      <= '0;
            mode_q    <= '0;
            valid_out <= 1'b0;
            buf_q     <= '0;
            out_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        buf_q  <= input_data;
                        mode_q <= mode;
                        beat   <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    out_q[beat] <= lane_res;
                    if (beat == LAST_BEAT) begin
                        valid_out <= 1'b1;
                        beat      <= '0;
                        state     <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_act_unit_par.sv
// Directed, table-driven bench for act_unit_par with hand-written handshake/reset sequences.

module tb_act_unit_par;
    localparam int DW    = 16;
    localparam int NCH   = 64;
    localparam int LN    = 8;
    localparam int BEATS = NCH / LN;
`ifdef ACT_LEAKY_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    typedef logic [NCH-1:0][DW-1:0] vecd_t;
    typedef struct {
        logic [1:0]  mode;
        logic [15:0] fill;
        logic [15:0] fill_exp;
        int          idx[4];
        logic [15:0] val[4];
        logic [15:0] exp[4];
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic [1:0]  mode;
    vecd_t       input_data;
    vecd_t       output_data;
    logic        valid_out;
    logic        ready_in;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int acc[$];
    vec_t vecs[6];

    act_unit_par #(
        .DATA_W(DW), .FRAC_W(12), .N_CH(NCH), .LANES(LN), .LEAK_SHIFT(3), .CLIP_VAL(24576)
    ) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .mode(mode), .input_data(input_data), .output_data(output_data),
        .valid_out(valid_out), .ready_in(ready_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && valid_in && ready_out) acc.push_back(cyc);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vecd_t build_in(vec_t r);
        vecd_t v;
        for (int c = 0; c < NCH; c++) v[c] = r.fill;
        for (int i = 0; i < 4; i++) v[r.idx[i]] = r.val[i];
        return v;
    endfunction

    function automatic vecd_t build_exp(vec_t r);
        vecd_t v;
        for (int c = 0; c < NCH; c++) v[c] = r.fill_exp;
        for (int i = 0; i < 4; i++) v[r.idx[i]] = r.exp[i];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input vecd_t exp);
        int bad;
        n_chk++;
        if (output_data !== exp) begin
            n_fail++;
            bad = -1;
            for (int c = NCH - 1; c >= 0; c--) if (output_data[c] !== exp[c]) bad = c;
            $display("FAIL %s: ch%0d got %h expected %h", nm, bad, output_data[bad], exp[bad]);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid_out && n < 30) begin
            step();
            n++;
        end
    endtask

    // Present a vector, step through the accepting edge, then scramble inputs.
    task automatic accept(input vec_t r);
        int n;
        input_data = build_in(r);
        mode       = r.mode;
        valid_in   = 1'b1;
        n = 0;
        while (!ready_out && n < 30) begin
            step();
            n++;
        end
        step();
        valid_in   = 1'b0;
        mode       = ~r.mode;
        input_data = ~input_data;
        chk("accept_busy", ready_out, 0);
    endtask

    task automatic run_vec(input vec_t r, input string nm);
        int n;
        accept(r);
        wait_valid(n);
        chk({nm, "_latency"}, n, BEATS);
        chk_vec({nm, "_data"}, build_exp(r));
        ready_in = 1'b1;
        step();
        chk({nm, "_valid_drop"}, valid_out, 0);
        chk({nm, "_ready_back"}, ready_out, 1);
        ready_in = 1'b0;
    endtask

    initial begin
        int n;
        vec_t b2b[3];

        vecs[0] = '{2'd0, 16'h1000, 16'h1000, '{5, 63, 0, 1},
                    '{16'hF000, 16'h8000, 16'h1000, 16'h7FFF},
                    '{16'h0000, 16'h0000, 16'h1000, 16'h7FFF}};
        vecs[1] = '{2'd1, 16'h0000, 16'h0000, '{0, 1, 2, 3},
                    '{16'hF000, 16'hFFFF, 16'h0800, 16'h8000},
                    '{LK ? 16'hFE00 : 16'h0, LK ? 16'hFFFF : 16'h0, 16'h0800, LK ? 16'hF000 : 16'h0}};
        vecs[2] = '{2'd2, 16'h1000, 16'h1000, '{0, 1, 2, 3},
                    '{16'h7000, 16'h6000, 16'h5FFF, 16'h8001},
                    '{16'h6000, 16'h6000, 16'h5FFF, 16'h0000}};
        vecs[3] = '{2'd3, 16'hC000, 16'h0000, '{0, 1, 2, 3},
                    '{16'h1234, 16'h7FFF, 16'h8000, 16'h0001},
                    '{16'h1234, 16'h7FFF, 16'h0000, 16'h0001}};
        vecs[4] = '{2'd2, 16'h7FFF, 16'h6000, '{62, 63, 7, 8},
                    '{16'h0000, 16'h6001, 16'hFFFF, 16'h0001},
                    '{16'h0000, 16'h6000, 16'h0000, 16'h0001}};
        vecs[5] = '{2'd1, 16'hFFF8, LK ? 16'hFFFF : 16'h0, '{0, 1, 2, 3},
                    '{16'hFFF9, 16'h0000, 16'hFFF0, 16'h7FFF},
                    '{LK ? 16'hFFFF : 16'h0, 16'h0000, LK ? 16'hFFFE : 16'h0, 16'h7FFF}};

        reset = 1'b0; valid_in = 1'b0; ready_in = 1'b0; mode = 2'd0; input_data = '0;
        step(); step(); step();
        chk("reset_ready_out", ready_out, 1);
        chk("reset_valid_out", valid_out, 0);
        chk_vec("reset_data", '0);
        reset = 1'b1;
        step();

        for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        ready_in = 1'b1;
        step();
        chk("idle_ready_in_no_effect", valid_out, 0);
        ready_in = 1'b0;

        // Backpressure: held result, new vector with a different mode waiting upstream
        accept(vecs[2]);
        wait_valid(n);
        chk("bp_latency", n, BEATS);
        input_data = build_in(vecs[0]);
        mode       = vecs[0].mode;
        valid_in   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_valid", valid_out, 1);
            chk("bp_hold_ready_out", ready_out, 0);
            chk_vec("bp_hold_data", build_exp(vecs[2]));
        end
        ready_in = 1'b1;
        step();
        chk("bp_handshake_valid", valid_out, 0);
        chk("bp_handshake_ready", ready_out, 1);
        ready_in = 1'b0;
        step();
        chk("bp_next_accepted", ready_out, 0);
        valid_in = 1'b0;
        mode     = 2'd2;
        wait_valid(n);
        chk("bp_next_latency", n, BEATS);
        chk_vec("bp_next_data", build_exp(vecs[0]));
        ready_in = 1'b1;
        step();
        ready_in = 1'b0;

        // Reset at beat 4
        accept(vecs[1]);
        for (int i = 0; i < 4; i++) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rst_mid_ready_out", ready_out, 1);
        chk("rst_mid_valid_out", valid_out, 0);
        chk_vec("rst_mid_data", '0);
        run_vec(vecs[3], "after_rst");

        // Back-to-back with ready_in tied high
        b2b[0] = vecs[4]; b2b[1] = vecs[5]; b2b[2] = vecs[0];
        ready_in   = 1'b1;
        input_data = build_in(b2b[0]);
        mode       = b2b[0].mode;
        valid_in   = 1'b1;
        acc.delete();
        for (int v = 0; v < 3; v++) begin
            n = 0;
            while (ready_out && n < 30) begin
                step();
                n++;
            end
            chk("b2b_accept_wait", n, 1);
            if (v < 2) begin
                input_data = build_in(b2b[v+1]);
                mode       = b2b[v+1].mode;
            end else begin
                valid_in = 1'b0;
            end
            wait_valid(n);
            chk("b2b_latency", n, BEATS);
            chk_vec($sformatf("b2b_data%0d", v), build_exp(b2b[v]));
            step();
            chk("b2b_valid_pulse", valid_out, 0);
        end
        ready_in = 1'b0;
        chk("b2b_accept_count", acc.size(), 3);
        if (acc.size() == 3) begin
            chk("b2b_spacing01", acc[1] - acc[0], BEATS + 2);
            chk("b2b_spacing12", acc[2] - acc[1], BEATS + 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/act_unit_par.md
# act_unit_par

Parametrised, multi-mode activation stage for the CO-extraction network datapath. It accepts one N_CH-wide vector of signed fixed-point activations from the upstream layer and applies ReLU, leaky ReLU or clipped ReLU to each element, processing LANES channels per cycle to bound combinational area. It presents the result vector with a valid/ready handshake toward the next layer. It supersedes the fixed 64-channel, always-ready ReLU stage.

## Interface
- DATA_W, 16, element width (signed, two's complement)
- FRAC_W, 12, fractional bits (Q4.12 by default)
- N_CH, 64, channels per vector; N_CH % LANES == 0 required
- LANES, 8, elements processed per cycle; BEATS = N_CH/LANES
- LEAK_SHIFT, 3, leaky slope = 2^-LEAK_SHIFT
- CLIP_VAL, 24576, clipped-ReLU ceiling (6.0 in Q4.12), must be > 0
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- valid_in  input  1  upstream vector valid
- ready_out  output  1  block can accept a vector
- mode  input  2  0 ReLU, 1 leaky ReLU, 2 clipped ReLU, 3 reserved (treated as ReLU)
- input_data  input  DATA_W x N_CH  signed input vector
- output_data  output  DATA_W x N_CH  registered result vector
- valid_out  output  1  output vector valid
- ready_in  input  1  downstream accepts output vector

## Operation
- FSM states IDLE, BUSY, DONE. Reset (reset==0 at an edge): state IDLE, beat counter 0, valid_out 0, all output_data 0, input buffer 0.
- ready_out = (state == IDLE), combinational from state.
- IDLE: on valid_in && ready_out, capture input_data into internal buffer, latch mode, beat = 0, go BUSY. Inputs are not sampled in any other state.
- BUSY: each cycle, write output_data[beat*LANES +: LANES] from the buffered elements; beat increments. On beat == BEATS-1, set valid_out=1, go DONE, beat = 0.
- DONE: output_data and valid_out held stable. On ready_in, valid_out=0, go IDLE.
- Per-element functions (x signed DATA_W):
  - ReLU: x < 0 -> 0, else x.
  - Leaky: x < 0 -> x >>> LEAK_SHIFT (arithmetic shift, rounds toward -inf), else x.
  - Clipped: x < 0 -> 0; x > CLIP_VAL -> CLIP_VAL; else x.
- No arithmetic widening; all results fit in DATA_W.
- output_data slices not yet written in BUSY hold the previous vector's values and are not valid.

## Timing
- Accept at edge k; beats written at edges k+1 .. k+BEATS; valid_out high after edge k+BEATS (8 cycles for defaults).
- Handshake completes on the edge where valid_out && ready_in; ready_out high in the following cycle; next accept no earlier than one cycle after that. Throughput: one vector per BEATS+2 cycles with ready_in tied high.
- valid_in while ready_out=0 is ignored; upstream must hold valid_in until accepted.
- ready_in asserted while not in DONE has no effect.
- Reset mid-BUSY or mid-DONE: next cycle in IDLE, valid_out 0, output_data 0, partial vector discarded.
- mode changes after acceptance do not affect the vector in flight.

## Configuration
- ACT_LEAKY_EN defined: leaky ReLU (mode 1) implemented as above.
- ACT_LEAKY_EN undefined: no leaky shift logic; mode 1 is treated as ReLU (identical to mode 0 and 3). All other behaviour unchanged.

## Test plan
- ReLU, defaults: vector of all 0x1000 except ch5=0xF000, ch63=0x8000 -> valid_out 8 cycles after accept; ch5=0, ch63=0, others 0x1000.
- Leaky (ACT_LEAKY_EN): ch0=0xF000, ch1=0xFFFF, ch2=0x0800 -> 0xFE00, 0xFFFF, 0x0800; with macro undefined, same stimulus -> 0, 0, 0x0800.
- Clipped: ch0=0x7000, ch1=0x6000, ch2=0x5FFF, ch3=0x8001 -> 0x6000, 0x6000, 0x5FFF, 0.
- Backpressure: ready_in low 5 cycles after valid_out rises, valid_in high throughout with a new vector -> output_data and valid_out stable, ready_out 0, new vector accepted only in IDLE after the handshake, mode change during hold has no effect.
- Reset mid-operation: drop reset for one edge at beat 4 -> next cycle state IDLE, ready_out 1, valid_out 0, output_data all 0; subsequent vector processes normally.
- Back-to-back: 3 vectors with ready_in tied high -> each result correct, valid_out pulses one cycle, accepts spaced exactly BEATS+2 cycles.
